// File: rtl/axi_mem_slave_pkg.sv
// Shared definitions for the AXI-style memory responder: default widths,
// write-response codes and the read-channel state encoding.
package axi_mem_slave_pkg;

    localparam int ID_W_DEF   = 3;
    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_mem_array.sv
// DEPTH x DATA_W register file: async clear, combinational read port,
// synchronous write port with write enable.
module axi_mem_array #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: cleared on reset, written on enable.
    // NOTE: this array carries a reset because clearing it is visible behaviour
    // (reads after reset must return zero); a plain RAM would normally have none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port sees the pre-edge contents, so a same-edge read returns old data.
    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_slave.sv
// AXI-style memory responder: independent read FSM and write collection /
// commit path in front of a small register file.
module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    // read address channel
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVLD,
    output logic              ARRDY,
    // read data channel
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic              RVLD,
    input  logic              RRDY,
    // write address channel
    input  logic [ID_W-1:0]   AWID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVLD,
    output logic              AWRDY,
    // write data channel
    input  logic [ID_W-1:0]   WID,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WVLD,
    output logic              WRDY,
    // write response channel
    output logic [ID_W-1:0]   BID,
    output logic              BRESP,
    output logic              BVLD,
    input  logic              BRDY
);

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_e         rd_state, rd_state_nxt;
    logic [DATA_W-1:0] mem_rdata;
    logic              ar_hs;

    assign ar_hs = ARVLD && ARRDY;

    // Read FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_state_nxt;
        end
    end

    // Read FSM next state and channel handshake outputs.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        rd_state_nxt = rd_state;
        ARRDY        = 1'b0;
        RVLD         = 1'b0;
        case (rd_state)
            R_IDLE: begin
                ARRDY = 1'b1;
                if (ARVLD) rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                RVLD = 1'b1;
                if (RRDY) rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read payload: captured on the AR handshake, held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RID   <= '0;
            RDATA <= '0;
        end else if (ar_hs) begin
            RID   <= ARID;
            RDATA <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic              aw_held, w_held;
    logic [ID_W-1:0]   aw_id, w_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_data;
    logic              aw_hs, w_hs, commit, id_match;

    assign AWRDY    = !aw_held && !BVLD;
    assign WRDY     = !w_held && !BVLD;
    assign aw_hs    = AWVLD && AWRDY;
    assign w_hs     = WVLD && WRDY;
    assign commit   = aw_held && w_held;
    assign id_match = (w_id == aw_id);

    // Write collection: AW and W latch independently; both clear on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            aw_id   <= '0;
            aw_addr <= '0;
            w_held  <= 1'b0;
            w_id    <= '0;
            w_data  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_id   <= AWID;
                aw_addr <= AWADDR;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_id   <= WID;
                w_data <= WDATA;
            end
        end
    end

    // B channel: loaded on commit, held until the B handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BVLD  <= 1'b0;
            BID   <= '0;
            BRESP <= RESP_OKAY;
        end else if (commit) begin
            BVLD  <= 1'b1;
            BID   <= aw_id;
            BRESP <= id_match ? RESP_OKAY : RESP_ERR;
        end else if (BVLD && BRDY) begin
            BVLD  <= 1'b0;
        end
    end

    axi_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit && id_match),
        .waddr (aw_addr),
        .wdata (w_data),
        .raddr (ARADDR),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: transaction-level reference model,
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_axi_mem_slave;

    localparam int ID_W   = 3;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst_n;
    logic [ID_W-1:0]   ARID, RID, AWID, WID, BID;
    logic [ADDR_W-1:0] ARADDR, AWADDR;
    logic [DATA_W-1:0] RDATA, WDATA;
    logic              ARVLD, ARRDY, RVLD, RRDY;
    logic              AWVLD, AWRDY, WVLD, WRDY;
    logic              BRESP, BVLD, BRDY;

    axi_mem_slave #(
        .ID_W   (ID_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ARID   (ARID),
        .ARADDR (ARADDR),
        .ARVLD  (ARVLD),
        .ARRDY  (ARRDY),
        .RID    (RID),
        .RDATA  (RDATA),
        .RVLD   (RVLD),
        .RRDY   (RRDY),
        .AWID   (AWID),
        .AWADDR (AWADDR),
        .AWVLD  (AWVLD),
        .AWRDY  (AWRDY),
        .WID    (WID),
        .WDATA  (WDATA),
        .WVLD   (WVLD),
        .WRDY   (WRDY),
        .BID    (BID),
        .BRESP  (BRESP),
        .BVLD   (BVLD),
        .BRDY   (BRDY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s timeout waiting for handshake t=%0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a read slot, a pending-write pair and a response slot.
    // ------------------------------------------------------------------
    logic              m_r_busy, m_aw_held, m_w_held, m_b_busy;
    logic [ID_W-1:0]   m_rid, m_aw_id, m_w_id, m_bid;
    logic [ADDR_W-1:0] m_aw_addr;
    logic [DATA_W-1:0] m_rdata, m_w_data;
    logic              m_bresp;
    logic [DATA_W-1:0] m_mem [DEPTH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r_busy  <= 1'b0;
            m_rid     <= '0;
            m_rdata   <= '0;
            m_aw_held <= 1'b0;
            m_w_held  <= 1'b0;
            m_aw_id   <= '0;
            m_w_id    <= '0;
            m_aw_addr <= '0;
            m_w_data  <= '0;
            m_b_busy  <= 1'b0;
            m_bid     <= '0;
            m_bresp   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
        end else begin
            // a read is accepted whenever nothing is outstanding
            if (!m_r_busy && ARVLD) begin
                m_r_busy <= 1'b1;
                m_rid    <= ARID;
                m_rdata  <= m_mem[ARADDR];
            end else if (m_r_busy && RRDY) begin
                m_r_busy <= 1'b0;
            end
            // write: commit once both halves are present, otherwise collect
            if (m_aw_held && m_w_held) begin
                if (m_aw_id == m_w_id) m_mem[m_aw_addr] <= m_w_data;
                m_bresp   <= (m_aw_id != m_w_id);
                m_bid     <= m_aw_id;
                m_b_busy  <= 1'b1;
                m_aw_held <= 1'b0;
                m_w_held  <= 1'b0;
            end else begin
                if (!m_aw_held && !m_b_busy && AWVLD) begin
                    m_aw_held <= 1'b1;
                    m_aw_id   <= AWID;
                    m_aw_addr <= AWADDR;
                end
                if (!m_w_held && !m_b_busy && WVLD) begin
                    m_w_held <= 1'b1;
                    m_w_id   <= WID;
                    m_w_data <= WDATA;
                end
                if (m_b_busy && BRDY) m_b_busy <= 1'b0;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_arrdy", 32'(ARRDY), 32'(!m_r_busy));
            check("cmp_rvld",  32'(RVLD),  32'(m_r_busy));
            if (m_r_busy) begin
                check("cmp_rid",   32'(RID),   32'(m_rid));
                check("cmp_rdata", 32'(RDATA), 32'(m_rdata));
            end
            check("cmp_awrdy", 32'(AWRDY), 32'(!m_aw_held && !m_b_busy));
            check("cmp_wrdy",  32'(WRDY),  32'(!m_w_held && !m_b_busy));
            check("cmp_bvld",  32'(BVLD),  32'(m_b_busy));
            if (m_b_busy) begin
                check("cmp_bid",   32'(BID),   32'(m_bid));
                check("cmp_bresp", 32'(BRESP), 32'(m_bresp));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr);
        bit done;
        done   = 1'b0;
        ARID   = id;
        ARADDR = addr;
        ARVLD  = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = ARRDY;
            tick();
        end
        ARVLD = 1'b0;
        if (!done) timeout_fail("ar_hs");
    endtask

    task automatic send_write(input bit do_aw, input bit do_w,
                              input logic [ID_W-1:0] aw_id, input logic [ADDR_W-1:0] addr,
                              input logic [ID_W-1:0] w_id, input logic [DATA_W-1:0] data);
        bit a_hs, w_hs;
        AWID   = aw_id;
        AWADDR = addr;
        AWVLD  = do_aw;
        WID    = w_id;
        WDATA  = data;
        WVLD   = do_w;
        for (int i = 0; i < 50 && (AWVLD || WVLD); i++) begin
            @(negedge clk);
            a_hs = AWVLD && AWRDY;
            w_hs = WVLD && WRDY;
            tick();
            if (a_hs) AWVLD = 1'b0;
            if (w_hs) WVLD  = 1'b0;
        end
        if (AWVLD || WVLD) timeout_fail("aw_w_hs");
        AWVLD = 1'b0;
        WVLD  = 1'b0;
    endtask

    // Returns at the negedge where RVLD is first seen; lat counts negedges.
    task automatic wait_r(output logic [ID_W-1:0] id, output logic [DATA_W-1:0] data, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = RVLD;
        end
        id   = RID;
        data = RDATA;
        if (!seen) timeout_fail("r_vld");
    endtask

    task automatic wait_b(output logic [ID_W-1:0] id, output logic resp, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = BVLD;
        end
        id   = BID;
        resp = BRESP;
        if (!seen) timeout_fail("b_vld");
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] exp_data, input string tag);
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rd;
        int                lat;
        send_ar(id, addr);
        wait_r(rid, rd, lat);
        check({tag, "_rlat"},  32'(lat), 1);
        check({tag, "_rid"},   32'(rid), 32'(id));
        check({tag, "_rdata"}, 32'(rd),  32'(exp_data));
        tick();
    endtask

    task automatic expect_b(input logic [ID_W-1:0] exp_id, input logic exp_resp, input string tag);
        logic [ID_W-1:0] bid;
        logic            bresp;
        int              lat;
        wait_b(bid, bresp, lat);
        check({tag, "_blat"},  32'(lat),   2);
        check({tag, "_bid"},   32'(bid),   32'(exp_id));
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
    endtask

    // Hard stop if anything hangs despite the per-wait bounds.
    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [ID_W-1:0] bid;
        logic            bresp;
        int              lat;
        bit              ar_r, aw_r, w_r;

        rst_n = 1'b0;
        ARID = '0; ARADDR = '0; ARVLD = 1'b0; RRDY = 1'b1;
        AWID = '0; AWADDR = '0; AWVLD = 1'b0;
        WID  = '0; WDATA  = '0; WVLD  = 1'b0; BRDY = 1'b1;

        // reset values
        #1;
        check("rst_arrdy", 32'(ARRDY), 1);
        check("rst_awrdy", 32'(AWRDY), 1);
        check("rst_wrdy",  32'(WRDY),  1);
        check("rst_rvld",  32'(RVLD),  0);
        check("rst_bvld",  32'(BVLD),  0);
        check("rst_rid",   32'(RID),   0);
        check("rst_rdata", 32'(RDATA), 0);
        check("rst_bid",   32'(BID),   0);
        check("rst_bresp", 32'(BRESP), 0);
        repeat (2) tick();
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick();

        // write then read, AW and W in the same cycle
        send_write(1'b1, 1'b1, 3'd1, 3'd5, 3'd1, 8'hA5);
        expect_b(3'd1, 1'b0, "wr1");
        tick();
        do_read(3'd2, 3'd5, 8'hA5, "rd1");

        // W ahead of AW
        send_write(1'b0, 1'b1, 3'd3, 3'd0, 3'd3, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wfirst_wrdy", 32'(WRDY), 0);
            tick();
        end
        send_write(1'b1, 1'b0, 3'd3, 3'd2, 3'd0, 8'h00);
        expect_b(3'd3, 1'b0, "wfirst");
        tick();
        do_read(3'd0, 3'd2, 8'h3C, "rd_wfirst");

        // ID mismatch: error response, memory untouched
        send_write(1'b1, 1'b1, 3'd1, 3'd0, 3'd2, 8'hFF);
        expect_b(3'd1, 1'b1, "mism");
        tick();
        do_read(3'd4, 3'd0, 8'h00, "rd_mism");

        // R back-pressure
        send_write(1'b1, 1'b1, 3'd4, 3'd7, 3'd4, 8'h5A);
        expect_b(3'd4, 1'b0, "wr7");
        tick();
        RRDY = 1'b0;
        send_ar(3'd5, 3'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rbp_rvld",  32'(RVLD),  1);
            check("rbp_rid",   32'(RID),   5);
            check("rbp_rdata", 32'(RDATA), 'h5A);
            check("rbp_arrdy", 32'(ARRDY), 0);
            tick();
        end
        RRDY = 1'b1;
        tick();
        @(negedge clk);
        check("rbp_done_rvld",  32'(RVLD),  0);
        check("rbp_done_arrdy", 32'(ARRDY), 1);
        tick();

        // B back-pressure
        BRDY = 1'b0;
        send_write(1'b1, 1'b1, 3'd6, 3'd3, 3'd6, 8'h77);
        expect_b(3'd6, 1'b0, "bbp");
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bbp_bvld",  32'(BVLD),  1);
            check("bbp_bid",   32'(BID),   6);
            check("bbp_bresp", 32'(BRESP), 0);
            check("bbp_awrdy", 32'(AWRDY), 0);
            check("bbp_wrdy",  32'(WRDY),  0);
            tick();
        end
        BRDY = 1'b1;
        tick();
        @(negedge clk);
        check("bbp_done_bvld",  32'(BVLD),  0);
        check("bbp_done_awrdy", 32'(AWRDY), 1);
        tick();

        // collision: AR handshake on the commit edge sees the old value
        send_write(1'b1, 1'b1, 3'd1, 3'd4, 3'd1, 8'h11);
        expect_b(3'd1, 1'b0, "col_pre");
        tick();
        AWID = 3'd1; AWADDR = 3'd4; AWVLD = 1'b1;
        WID  = 3'd1; WDATA  = 8'h22; WVLD = 1'b1;
        @(negedge clk);
        check("col_awrdy", 32'(AWRDY), 1);
        tick();
        AWVLD = 1'b0; WVLD = 1'b0;
        ARID = 3'd7; ARADDR = 3'd4; ARVLD = 1'b1;
        @(negedge clk);
        check("col_arrdy", 32'(ARRDY), 1);
        tick();
        ARVLD = 1'b0;
        @(negedge clk);
        check("col_rvld",  32'(RVLD),  1);
        check("col_rdata", 32'(RDATA), 'h11);
        check("col_bvld",  32'(BVLD),  1);
        tick();
        do_read(3'd2, 3'd4, 8'h22, "col_after");

        // randomized traffic, checked by the compare process
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ar_r = ARRDY;
            aw_r = AWRDY;
            w_r  = WRDY;
            tick();
            if (ARVLD && ar_r) ARVLD = 1'b0;
            if (AWVLD && aw_r) AWVLD = 1'b0;
            if (WVLD && w_r)   WVLD  = 1'b0;
            if (!ARVLD && $urandom_range(0, 2) == 0) begin
                ARVLD  = 1'b1;
                ARID   = 3'($urandom_range(0, 7));
                ARADDR = 3'($urandom_range(0, 7));
            end
            if (!AWVLD && $urandom_range(0, 2) == 0) begin
                AWVLD  = 1'b1;
                AWID   = 3'($urandom_range(0, 1));
                AWADDR = 3'($urandom_range(0, 7));
            end
            if (!WVLD && $urandom_range(0, 2) == 0) begin
                WVLD  = 1'b1;
                WID   = 3'($urandom_range(0, 1));
                WDATA = 8'($urandom_range(1, 255));
            end
            RRDY = ($urandom_range(0, 3) != 0);
            BRDY = ($urandom_range(0, 3) != 0);
        end
        ARVLD = 1'b0; AWVLD = 1'b0; WVLD = 1'b0;
        RRDY  = 1'b1; BRDY  = 1'b1;
        repeat (5) tick();

        // reset in the middle of a read and a half-collected write
        RRDY = 1'b0;
        send_ar(3'd5, 3'd1);
        send_write(1'b1, 1'b0, 3'd2, 3'd1, 3'd0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_arrdy", 32'(ARRDY), 1);
        check("mid_rvld",  32'(RVLD),  0);
        check("mid_rid",   32'(RID),   0);
        check("mid_rdata", 32'(RDATA), 0);
        check("mid_awrdy", 32'(AWRDY), 1);
        check("mid_wrdy",  32'(WRDY),  1);
        check("mid_bvld",  32'(BVLD),  0);
        check("mid_bid",   32'(BID),   0);
        check("mid_bresp", 32'(BRESP), 0);
        RRDY = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        send_write(1'b0, 1'b1, 3'd2, 3'd0, 3'd2, 8'hEE);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lone_w_bvld",  32'(BVLD),  0);
            check("lone_w_awrdy", 32'(AWRDY), 1);
            tick();
        end
        for (int a = 0; a < DEPTH; a++) begin
            do_read(3'(a), 3'(a), 8'h00, "rst_mem");
        end

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
